// File: rtl/cla_adder_arbiter_if.sv
// Bus bundle between two requesters, the result consumer, the shared adder and the arbiter.
// The master side drives requests, rsp_ready and add_sum; the slave side is the arbiter.
interface cla_adder_arbiter_if #(
  parameter int DW = 11
);
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_op;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic          req1_op;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [DW-1:0] add_c;
  logic [DW-1:0] add_d;
  logic [DW:0]   add_sum;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW:0]   rsp_result;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  add_c, add_d,
    output add_sum,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output add_c, add_d,
    input  add_sum,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready
  );
endinterface

// File: rtl/cla_adder_arbiter.sv
// Round-robin arbiter time-sharing one combinational DW-bit adder (no carry-in) between two requesters.
// SUB takes two adder passes: first forms the two's complement of b, then adds it to a.
module cla_adder_arbiter #(
  parameter int   DW      = 11,
  parameter logic RR_INIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  cla_adder_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, NEG = 2'd1, EXEC = 2'd2, RESP = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic          op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW:0]   t_q, t_d;
  logic [DW:0]   result_q, result_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;

  logic          gnt_any;
  logic          gnt_id;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_any = bus.req0_valid | bus.req1_valid;
    gnt_id  = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= RR_INIT;
      id_q        <= 1'b0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      t_q         <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      t_q         <= t_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    t_d         = t_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          id_d    = gnt_id;
          last_d  = gnt_id;
          op_d    = gnt_id ? bus.req1_op : bus.req0_op;
          a_d     = gnt_id ? bus.req1_a : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b : bus.req0_b;
          state_d = (gnt_id ? bus.req1_op : bus.req0_op) ? NEG : EXEC;
        end
      end
      NEG: begin
        t_d     = bus.add_sum;
        state_d = EXEC;
      end
      EXEC: begin
        // t[DW] is set only when b was zero, where the second pass cannot carry out.
        result_d    = op_q ? {bus.add_sum[DW] | t_q[DW], bus.add_sum[DW-1:0]} : bus.add_sum;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.add_c      = '0;
    bus.add_d      = '0;
    case (state_q)
      IDLE: begin
        if (!rst && gnt_any) begin
          bus.req0_ready = ~gnt_id;
          bus.req1_ready = gnt_id;
        end
      end
      NEG: begin
        bus.add_c = ~b_q;
        bus.add_d = {{(DW-1){1'b0}}, 1'b1};
      end
      EXEC: begin
        bus.add_c = a_q;
        bus.add_d = op_q ? t_q[DW-1:0] : b_q;
      end
      default: ;
    endcase
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = result_q;

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Self-checking bench: directed vector table, corner sequences, and randomized traffic against
// an arithmetic reference model with a response scoreboard.
module tb_cla_adder_arbiter;
  localparam int DW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_adder_arbiter_if #(.DW(DW)) bus ();

  // The external shared adder.
  assign bus.add_sum = {1'b0, bus.add_c} + {1'b0, bus.add_d};

  cla_adder_arbiter #(.DW(DW), .RR_INIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            id;
    logic          op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [DW:0] res;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW:0] ref_result(input logic op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    if (op == 1'b0) return 12'(ia + ib);
    return {(ia >= ib), 11'((ia - ib + 2048) % 2048)};
  endfunction

  task automatic set_req(input int id, input logic v, input logic op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one operation; returns the response fields and cycles from handshake to rsp_valid.
  task automatic do_op(input int id, input logic op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, output logic [DW:0] res, output logic rid,
                       output int lat);
    int n;
    n = 0;
    @(negedge clk);
    set_req(id, 1'b1, op, a, b);
    #1;
    while (!rdy(id) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL hs_timeout: req%0d ready never seen, expected within 20 cycles", id);
    end
    @(negedge clk);
    set_req(id, 1'b0, op, a, b);
    lat = 1;
    #1;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    res = bus.rsp_result;
    rid = bus.rsp_id;
  endtask

  vec_t          vecs[8];
  exp_t          exp_q[$];
  logic [DW:0]   res;
  logic          rid;
  int            lat;
  int            grants[4];
  int            exp_g[4];
  int            n_g;
  int            both_cnt;
  int            stale_cnt;
  logic [DW-1:0] pa[2];
  logic [DW-1:0] pb[2];
  logic          pop[2];
  bit            pend[2];
  bit            busy;
  logic          last_m;
  int            eg;
  int            got;
  exp_t          e;

  initial begin
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, '0, '0);
    bus.rsp_ready = 1'b1;

    // Reset state with requests pending: nothing may be granted.
    repeat (2) @(negedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_add_c", bus.add_c, 0);
    check("rst_add_d", bus.add_d, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);

    // ADD 0x7FF + 0x001: adder inputs in EXEC and latency of 2.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 11'h7FF, 11'h001);
    #1;
    check("add_hs_ready0", bus.req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    check("add_exec_c", bus.add_c, 'h7FF);
    check("add_exec_d", bus.add_d, 'h001);
    check("add_t1_valid", bus.rsp_valid, 0);
    @(negedge clk);
    #1;
    check("add_t2_valid", bus.rsp_valid, 1);
    check("add_t2_id", bus.rsp_id, 0);
    check("add_t2_result", bus.rsp_result, 'h800);
    $display("txn hand ADD id=0 a=7ff b=001 result=%03h", bus.rsp_result);

    // SUB 0x005 - 0x003 on requester 1: negation pass inputs, latency of 3.
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 11'h005, 11'h003);
    #1;
    check("sub_hs_ready1", bus.req1_ready, 1);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, '0, '0);
    #1;
    check("sub_neg_c", bus.add_c, 'h7FC);
    check("sub_neg_d", bus.add_d, 'h001);
    @(negedge clk);
    #1;
    check("sub_t2_valid", bus.rsp_valid, 0);
    @(negedge clk);
    #1;
    check("sub_t3_valid", bus.rsp_valid, 1);
    check("sub_t3_id", bus.rsp_id, 1);
    check("sub_t3_result", bus.rsp_result, 'h802);
    $display("txn hand SUB id=1 a=005 b=003 result=%03h", bus.rsp_result);

    // Directed vector table.
    vecs[0] = '{0, 1'b0, 11'h7FF, 11'h001, 12'h800};
    vecs[1] = '{1, 1'b1, 11'h005, 11'h003, 12'h802};
    vecs[2] = '{0, 1'b1, 11'h003, 11'h005, 12'h7FE};
    vecs[3] = '{1, 1'b1, 11'h123, 11'h000, 12'h923};
    vecs[4] = '{0, 1'b0, 11'h7FF, 11'h7FF, 12'hFFE};
    vecs[5] = '{1, 1'b0, 11'h000, 11'h000, 12'h000};
    vecs[6] = '{0, 1'b1, 11'h7FF, 11'h7FF, 12'h800};
    vecs[7] = '{1, 1'b1, 11'h000, 11'h7FF, 12'h001};
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, res, rid, lat);
      $display("txn vec%0d %s id=%0d a=%03h b=%03h result=%03h lat=%0d", i,
               vecs[i].op ? "SUB" : "ADD", vecs[i].id, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_id", i), rid, vecs[i].id);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].op ? 3 : 2);
    end

    // Both requesters continuously valid after reset: grants alternate starting with 0.
    apply_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 11'h011, 11'h022);
    set_req(1, 1'b1, 1'b0, 11'h033, 11'h044);
    exp_g = '{0, 1, 0, 1};
    n_g = 0;
    both_cnt = 0;
    for (int c = 0; c < 40 && n_g < 4; c++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both_cnt++;
      else if (bus.req0_ready || bus.req1_ready) begin
        grants[n_g] = bus.req1_ready ? 1 : 0;
        $display("txn grant%0d id=%0d", n_g, grants[n_g]);
        n_g++;
      end
      @(negedge clk);
    end
    check("rr_grant_count", n_g, 4);
    check("rr_never_both", both_cnt, 0);
    for (int i = 0; i < n_g; i++) check($sformatf("rr_grant%0d", i), grants[i], exp_g[i]);

    // Consumer stalls for 5 cycles: response held, nobody granted.
    apply_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 11'h155, 11'h2AA);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 11'h001, 11'h001);
    lat = 1;
    #1;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    check("stall_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      check($sformatf("stall%0d_valid", i), bus.rsp_valid, 1);
      check($sformatf("stall%0d_id", i), bus.rsp_id, 0);
      check($sformatf("stall%0d_result", i), bus.rsp_result, 'h3FF);
      check($sformatf("stall%0d_ready0", i), bus.req0_ready, 0);
      check($sformatf("stall%0d_ready1", i), bus.req1_ready, 0);
    end
    $display("txn stall ADD id=0 a=155 b=2aa result=%03h", bus.rsp_result);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("stall_release_valid", bus.rsp_valid, 0);
    check("stall_release_ready1", bus.req1_ready, 1);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);

    // Reset during the negation pass of a SUB discards it.
    apply_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 11'h0F0, 11'h00F);
    #1;
    check("rstneg_hs_ready0", bus.req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rstneg_neg_c", bus.add_c, 'h7F0);
    check("rstneg_neg_d", bus.add_d, 'h001);
    #1;
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 11'h001, 11'h002);
    #1;
    check("rstneg_add_c", bus.add_c, 0);
    check("rstneg_add_d", bus.add_d, 0);
    check("rstneg_valid", bus.rsp_valid, 0);
    check("rstneg_result", bus.rsp_result, 0);
    check("rstneg_ready0", bus.req0_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    stale_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.rsp_valid) stale_cnt++;
      @(negedge clk);
    end
    check("rstneg_no_stale", stale_cnt, 0);
    set_req(0, 1'b1, 1'b0, 11'h001, 11'h002);
    set_req(1, 1'b1, 1'b0, 11'h003, 11'h004);
    #1;
    check("rstneg_tie_ready0", bus.req0_ready, 1);
    check("rstneg_tie_ready1", bus.req1_ready, 0);

    // Randomized traffic against the reference model.
    apply_reset();
    pend = '{0, 0};
    busy = 1'b0;
    last_m = 1'b1;
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pop[r]  = 1'($urandom_range(0, 1));
          pa[r]   = 11'($urandom);
          pb[r]   = ($urandom_range(0, 7) == 0) ? 11'h000 : 11'($urandom);
        end
      end
      set_req(0, pend[0], pop[0], pa[0], pb[0]);
      set_req(1, pend[1], pop[1], pa[1], pb[1]);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (busy) eg = -1;
      else if (pend[0] && pend[1]) eg = last_m ? 0 : 1;
      else if (pend[0]) eg = 0;
      else if (pend[1]) eg = 1;
      else eg = -1;
      got = bus.req0_ready ? (bus.req1_ready ? 2 : 0) : (bus.req1_ready ? 1 : -1);
      check("rand_grant", got, eg);
      if (eg >= 0 && got == eg) begin
        e.id  = eg;
        e.res = ref_result(pop[eg], pa[eg], pb[eg]);
        exp_q.push_back(e);
        last_m   = eg[0];
        busy     = 1'b1;
        pend[eg] = 1'b0;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rand_unexpected_rsp: got id=%0d result=0x%0h, expected no response",
                   bus.rsp_id, bus.rsp_result);
        end else begin
          e = exp_q.pop_front();
          $display("txn rand id=%0d result=%03h", bus.rsp_id, bus.rsp_result);
          check("rand_rsp_id", bus.rsp_id, e.id);
          check("rand_rsp_result", bus.rsp_result, e.res);
        end
        busy = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
